demux1_7: RTL and testbench

DEMUX1_7 -- requirements
Module: demux1_7

---
 rtl/demux1_7.sv | 97 +++++++++
 tb/tb_demux1_7.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/demux1_7.sv
// demux1_7: serial-to-parallel 1:7 lane demultiplexer.
// Bits are placed into lanes 0..6 by an internal lane counter; the seventh
// bit completes a word that is handed to a single-entry output register.
// The output side is decoupled from collection: a word that completes while
// the previous one is still unconsumed is dropped and flagged by sticky overrun.
module demux1_7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic       d_valid,
  input  logic       flush,
  input  logic       out_ready,
  output logic [6:0] y,
  output logic       y_valid,
  output logic [2:0] lane,
  output logic       overrun
);

  localparam int unsigned WORD_W = 7;
  localparam int unsigned LANE_W = 3;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_W - 1);

  // Collection states: the lane counter itself encodes them.
  localparam logic [0:0] FILL_EMPTY = 1'b0;
  localparam logic [0:0] FILL       = 1'b1;

  // Only lanes 0..5 need storage; the lane-6 bit goes straight into the word.
  logic [WORD_W-2:0] partial_q, partial_d;
  logic [LANE_W-1:0] lane_d;
  logic [WORD_W-1:0] y_d;
  logic [WORD_W-1:0] word_c;
  logic              y_valid_d;
  logic              overrun_d;
  logic              accept_c;
  logic              complete_c;
  logic [0:0]        state_c;

  // Next-state and output computation.
  always_comb begin
    partial_d = partial_q;
    lane_d    = lane;
    y_d       = y;
    y_valid_d = y_valid;
    overrun_d = overrun;

    state_c    = (lane == '0) ? FILL_EMPTY : FILL;
    accept_c   = d_valid & ~flush;
    complete_c = accept_c & (lane == LAST_LANE);
    word_c     = {d, partial_q};

    if (flush) begin
      lane_d    = '0;
      partial_d = '0;
    end else if (d_valid) begin
      if (lane == LAST_LANE) begin
        lane_d = '0;
      end else begin
        partial_d[lane] = d;
        lane_d          = lane + LANE_W'(1);
      end
    end

    if (complete_c) begin
      if (!y_valid || out_ready) begin
        y_d       = word_c;
        y_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (y_valid && out_ready) begin
      y_valid_d = 1'b0;
    end

    // A wrapped counter always lands back in FILL_EMPTY.
    if (state_c == FILL && lane_d == '0) begin
      partial_d = partial_d;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      partial_q <= '0;
      lane      <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      partial_q <= partial_d;
      lane      <= lane_d;
      y         <= y_d;
      y_valid   <= y_valid_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_demux1_7.sv
// tb_demux1_7: directed self-checking bench for demux1_7.
module tb_demux1_7;

  logic       clk;
  logic       rst;
  logic       d;
  logic       d_valid;
  logic       flush;
  logic       out_ready;
  logic [6:0] y;
  logic       y_valid;
  logic [2:0] lane;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  demux1_7 dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .d_valid  (d_valid),
    .flush    (flush),
    .out_ready(out_ready),
    .y        (y),
    .y_valid  (y_valid),
    .lane     (lane),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic i_rst, input logic i_d, input logic i_dv,
                      input logic i_flush, input logic i_rdy);
    rst       = i_rst;
    d         = i_d;
    d_valid   = i_dv;
    flush     = i_flush;
    out_ready = i_rdy;
    @(posedge clk);
    #1;
  endtask

  // Send n bits, bits[i] going to lane i; out_ready is rdy, except last_rdy on the final bit.
  task automatic send(input logic [6:0] bits, input int n, input logic rdy, input logic last_rdy);
    for (int i = 0; i < n; i++) begin
      step(1'b0, bits[i], 1'b1, 1'b0, (i == n - 1) ? last_rdy : rdy);
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] ey, input logic eyv,
                         input logic [2:0] el, input logic eo);
    chk({tag, ".y"},       y,                 ey);
    chk({tag, ".y_valid"}, {6'b0, y_valid},   {6'b0, eyv});
    chk({tag, ".lane"},    {4'b0, lane},      {4'b0, el});
    chk({tag, ".overrun"}, {6'b0, overrun},   {6'b0, eo});
  endtask

  initial begin
    rst = 1'b1; d = 1'b0; d_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("reset", 7'b0000000, 1'b0, 3'd0, 1'b0);

    // First word 1,0,1,1,0,0,1 with out_ready low.
    send(7'b1001101, 3, 1'b0, 1'b0);
    chk("w1_mid.lane", {4'b0, lane}, 7'd3);
    chk("w1_mid.y_valid", {6'b0, y_valid}, 7'd0);
    send(7'b0001001 >> 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("w1", 7'b1001101, 1'b1, 3'd0, 1'b0);

    // Second word of all ones while y unconsumed: dropped, overrun set.
    send(7'b1111111, 7, 1'b0, 1'b0);
    chk_all("overrun", 7'b1001101, 1'b1, 3'd0, 1'b1);

    // Completion coinciding with consume replaces y without overrun.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(7'b1001101, 7, 1'b0, 1'b0);
    send(7'b0101010, 7, 1'b0, 1'b1);
    chk_all("replace", 7'b0101010, 1'b1, 3'd0, 1'b0);

    // Consume without completion: y_valid drops, y retained.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("consume.y_valid", {6'b0, y_valid}, 7'd0);
    chk("consume.y", y, 7'b0101010);
    // out_ready while empty has no effect.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_ready.y_valid", {6'b0, y_valid}, 7'd0);

    // Flush mid-word, with a simultaneous valid bit that must be discarded.
    send(7'b1111111, 4, 1'b0, 1'b0);
    chk("pre_flush.lane", {4'b0, lane}, 7'd4);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("flush", 7'b0101010, 1'b0, 3'd0, 1'b0);
    send(7'b1000000, 7, 1'b0, 1'b0);
    chk_all("post_flush", 7'b1000000, 1'b1, 3'd0, 1'b0);

    // Gapped input: d_valid toggles, all ones.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain.y_valid", {6'b0, y_valid}, 7'd0);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0), 1'b0, 1'b0);
      if (i == 1) chk("gap_hold.lane", {4'b0, lane}, 7'd1);
      if (i == 11) begin
        chk("gap6.lane", {4'b0, lane}, 7'd6);
        chk("gap6.y_valid", {6'b0, y_valid}, 7'd0);
      end
      if (i == 12) chk_all("gap7", 7'b1111111, 1'b1, 3'd0, 1'b0);
    end
    chk("gap_end.lane", {4'b0, lane}, 7'd0);

    // Reset mid-word with y_valid and overrun set.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(7'b0000011, 7, 1'b0, 1'b0);
    send(7'b1111111, 7, 1'b0, 1'b0);
    send(7'b1111111, 5, 1'b0, 1'b0);
    chk_all("pre_rst", 7'b0000011, 1'b1, 3'd5, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_all("mid_rst", 7'b0000000, 1'b0, 3'd0, 1'b0);
    send(7'b1100110, 1, 1'b0, 1'b0);
    chk("after_rst.lane", {4'b0, lane}, 7'd1);
    send(7'b1100110 >> 1, 6, 1'b0, 1'b0);
    chk_all("after_rst", 7'b1100110, 1'b1, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
